// File: rtl/avalon_input_pio_pkg.sv
// avalon_input_pio_pkg: register map and edge-type encodings shared by the input PIO.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package avalon_input_pio_pkg;

  // Register word addresses
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // EDGE_TYPE parameter encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Arming counter value at which edge detection is enabled
  localparam logic [1:0] ARM_DONE = 2'd3;

  // Saturating increment for the arming counter
  function automatic logic [1:0] arm_next(input logic [1:0] cnt);
    return (cnt == ARM_DONE) ? cnt : cnt + 2'd1;
  endfunction

endpackage

// File: rtl/pio_debouncer.sv
// pio_debouncer: shared prescaler plus per-bit two-sample agreement filter.
// Latency: 1..2 prescaler ticks from i_in to o_cond.
// Backpressure: none; free-running.
//
// Ports:
//   clk, reset_n : clock, async active-low reset
//   i_in         : synchronised inputs
//   o_cond       : debounced inputs (bit updates when two consecutive tick samples agree)
//   o_vld        : high once the first agreement update has happened
module pio_debouncer #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_cond,
  output logic             o_vld
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    r_cnt;
  logic             w_tick;
  logic [WIDTH-1:0] r_samp;
  logic             r_samp_vld;
  logic [WIDTH-1:0] r_cond;
  logic             r_vld;
  logic [WIDTH-1:0] w_agree;

  assign w_tick  = (r_cnt == LAST);
  assign w_agree = ~(i_in ^ r_samp);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_samp     <= '0;
      r_samp_vld <= 1'b0;
      r_cond     <= '0;
      r_vld      <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) begin
        r_samp     <= i_in;
        r_samp_vld <= 1'b1;
        // The very first sample has nothing to agree with, so it only primes r_samp.
        if (r_samp_vld) begin
          r_cond <= (r_cond & ~w_agree) | (i_in & w_agree);
          r_vld  <= 1'b1;
        end
      end
    end
  end

  assign o_cond = r_cond;
  assign o_vld  = r_vld;

endmodule

// File: rtl/avalon_input_pio.sv
// avalon_input_pio: Avalon-MM input PIO (sync, edge detect, edge capture, maskable level irq).
// Latency: read 1 clk; pin-to-DATA 2 clk (plus 1..2 debounce ticks with AVALON_INPUT_PIO_DEBOUNCE_EN).
// Backpressure: none; slave always accepts, fixed read latency.
//
// Optional feature macro: AVALON_INPUT_PIO_DEBOUNCE_EN (inserts pio_debouncer after the synchroniser).
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM slave write/read request
//   in_port               : asynchronous board inputs
//   readdata              : registered read data, zero-extended above WIDTH
//   irq                   : level interrupt, |(edge_capture & irq_mask)
module avalon_input_pio
  import avalon_input_pio_pkg::*;
#(
  parameter int               WIDTH           = 10,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_MASK      = '0,
  parameter int               DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_mask;
  logic [1:0]       r_arm;
  logic             r_irq;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_cond;
  logic             w_cond_vld;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdat;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_det;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;

`ifdef AVALON_INPUT_PIO_DEBOUNCE_EN
  pio_debouncer #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_in    (r_sync2),
    .o_cond  (w_cond),
    .o_vld   (w_cond_vld)
  );
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign w_cond     = r_sync2;
  assign w_cond_vld = 1'b1;
`endif

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic w_unused_wdata;
      assign w_unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  assign w_wr   = chipselect & ~write_n;
  assign w_wdat = writedata[WIDTH-1:0];
  assign w_rise = w_cond & ~r_prev;
  assign w_fall = ~w_cond & r_prev;
  assign w_clr  = (w_wr && address == ADDR_EDGE) ? w_wdat : '0;

  // Edges are ignored until the arming counter saturates, so levels already
  // present at reset release do not look like transitions from the reset 0.
  always_comb begin
    w_det = '0;
    if (r_arm == ARM_DONE) begin
      if (EDGE_TYPE == EDGE_RISE)      w_det = w_rise;
      else if (EDGE_TYPE == EDGE_FALL) w_det = w_fall;
      else                             w_det = w_rise | w_fall;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_cond;
      ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_mask;
      ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edge;
      default:   w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_edge     <= '0;
      r_mask     <= RESET_MASK;
      r_arm      <= '0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= w_cond;
      if (w_cond_vld) r_arm <= arm_next(r_arm);
      // Set wins over clear: a new edge in the W1C cycle is not lost.
      r_edge <= (r_edge & ~w_clr) | w_det;
      if (w_wr && address == ADDR_MASK) r_mask <= w_wdat;
      r_irq      <= |(r_edge & r_mask);
      r_readdata <= chipselect ? w_rd_mux : '0;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_avalon_input_pio.sv
// tb_avalon_input_pio: table-driven bench with a read scoreboard for avalon_input_pio.
// Two instances share the bus: rising-edge (mask reset 0) and any-edge (mask reset 0x00F).
// Multi-cycle corner cases (irq timing, set-vs-clear race, debounce, reset) are hand-written.
module tb_avalon_input_pio;

`ifdef AVALON_INPUT_PIO_DEBOUNCE_EN
  localparam int PIN_WAIT = 16;
  localparam int RST_WAIT = 20;
  localparam logic [9:0] MID_BIT = 10'h020;
`else
  localparam int PIN_WAIT = 6;
  localparam int RST_WAIT = 8;
  localparam logic [9:0] MID_BIT = 10'h004;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [9:0]  in_port;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  always #5 clk = ~clk;

  avalon_input_pio #(.WIDTH(10), .EDGE_TYPE(0), .RESET_MASK(10'h000), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  avalon_input_pio #(.WIDTH(10), .EDGE_TYPE(2), .RESET_MASK(10'h00F), .DEBOUNCE_CYCLES(4)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1)
  );

  typedef enum {OP_RD, OP_WR, OP_PIN, OP_IRQ} op_e;
  typedef struct {
    op_e        op;
    logic [1:0] addr;
    logic [9:0] dat;
    logic [9:0] exp;
    logic [9:0] exp_any;
  } vec_t;
  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] exp_any;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   total = 0;
  int   bad   = 0;
  logic rd_pend_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input op_e op, input logic [1:0] a, input logic [9:0] d,
                              input logic [9:0] e, input logic [9:0] ea);
    vec_t v;
    v.op = op; v.addr = a; v.dat = d; v.exp = e; v.exp_any = ea;
    vecs.push_back(v);
  endfunction

  // Scoreboard monitor: read data is valid one clock after the request.
  always @(posedge clk) rd_pend_q <= chipselect && write_n;

  always @(negedge clk) begin
    if (rd_pend_q) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check(e.name, rd0, e.exp);
        check({e.name, "_any"}, rd1, e.exp_any);
      end
    end
  end

  task automatic do_rd(input logic [1:0] a, input logic [9:0] e, input logic [9:0] ea, input string n);
    sb_t s;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    s.name = n; s.exp = {22'd0, e}; s.exp_any = {22'd0, ea};
    sb_q.push_back(s);
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic do_wr(input logic [1:0] a, input logic [9:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = {22'h3FFFFF, d};
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_pin(input logic [9:0] v);
    @(negedge clk);
    in_port = v;
    repeat (PIN_WAIT) @(negedge clk);
  endtask

  task automatic do_irq(input logic e, input logic ea, input string n);
    @(negedge clk);
    check(n, {31'd0, irq0}, {31'd0, e});
    check({n, "_any"}, {31'd0, irq1}, {31'd0, ea});
  endtask

  initial begin
    // Reset state with all inputs held high, then bus/mask/edge basics.
    add(OP_IRQ, 2'd0, 10'h000, 10'h000, 10'h000);
    add(OP_RD,  2'd3, 10'h000, 10'h000, 10'h000);
    add(OP_RD,  2'd0, 10'h000, 10'h3FF, 10'h3FF);
    add(OP_RD,  2'd2, 10'h000, 10'h000, 10'h00F);
    add(OP_RD,  2'd1, 10'h000, 10'h000, 10'h000);
    add(OP_WR,  2'd2, 10'h001, 10'h000, 10'h000);
    add(OP_RD,  2'd2, 10'h000, 10'h001, 10'h001);
    add(OP_PIN, 2'd0, 10'h3FE, 10'h000, 10'h000);
    add(OP_RD,  2'd3, 10'h000, 10'h000, 10'h001);
    add(OP_IRQ, 2'd0, 10'h000, 10'h000, 10'h001);
    add(OP_RD,  2'd0, 10'h000, 10'h3FE, 10'h3FE);
    add(OP_WR,  2'd3, 10'h3FF, 10'h000, 10'h000);
    add(OP_RD,  2'd3, 10'h000, 10'h000, 10'h000);
    add(OP_IRQ, 2'd0, 10'h000, 10'h000, 10'h000);

    reset_n = 1'b0; in_port = 10'h3FF; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'd0;
    repeat (3) @(negedge clk);
    #1 check("rst_readdata", rd0, 32'd0);
    reset_n = 1'b1;
    repeat (RST_WAIT) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_RD:  do_rd(vecs[i].addr, vecs[i].exp, vecs[i].exp_any, $sformatf("a_v%0d_rd", i));
        OP_WR:  do_wr(vecs[i].addr, vecs[i].dat);
        OP_PIN: do_pin(vecs[i].dat);
        default: do_irq(vecs[i].exp[0], vecs[i].exp_any[0], $sformatf("a_v%0d_irq", i));
      endcase
    end

    // bit0 rise: irq must be up within 4 clocks of the pin change.
    @(negedge clk);
    in_port = 10'h3FF;
`ifdef AVALON_INPUT_PIO_DEBOUNCE_EN
    repeat (PIN_WAIT) @(negedge clk);
`else
    repeat (4) @(negedge clk);
    check("irq_within_4", {31'd0, irq0}, 32'd1);
    repeat (2) @(negedge clk);
`endif

    vecs.delete();
    add(OP_RD,  2'd3, 10'h000, 10'h001, 10'h001);
    add(OP_WR,  2'd3, 10'h000, 10'h000, 10'h000);
    add(OP_RD,  2'd3, 10'h000, 10'h001, 10'h001);
    add(OP_WR,  2'd3, 10'h001, 10'h000, 10'h000);
    add(OP_IRQ, 2'd0, 10'h000, 10'h000, 10'h000);
    add(OP_RD,  2'd3, 10'h000, 10'h000, 10'h000);
    add(OP_WR,  2'd2, 10'h000, 10'h000, 10'h000);
    add(OP_PIN, 2'd0, 10'h000, 10'h000, 10'h000);
    add(OP_RD,  2'd3, 10'h000, 10'h000, 10'h3FF);
    add(OP_PIN, 2'd0, 10'h0A5, 10'h000, 10'h000);
    add(OP_RD,  2'd3, 10'h000, 10'h0A5, 10'h3FF);
    add(OP_IRQ, 2'd0, 10'h000, 10'h000, 10'h000);
    add(OP_RD,  2'd0, 10'h000, 10'h0A5, 10'h0A5);
    add(OP_WR,  2'd2, 10'h3FF, 10'h000, 10'h000);
    add(OP_IRQ, 2'd0, 10'h000, 10'h001, 10'h001);
    add(OP_RD,  2'd2, 10'h000, 10'h3FF, 10'h3FF);
    add(OP_WR,  2'd2, 10'h004, 10'h000, 10'h000);
    add(OP_IRQ, 2'd0, 10'h000, 10'h001, 10'h001);
    add(OP_WR,  2'd2, 10'h002, 10'h000, 10'h000);
    add(OP_IRQ, 2'd0, 10'h000, 10'h000, 10'h001);
    add(OP_WR,  2'd3, 10'h3FF, 10'h000, 10'h000);
    add(OP_RD,  2'd3, 10'h000, 10'h000, 10'h000);
    add(OP_IRQ, 2'd0, 10'h000, 10'h000, 10'h000);
    add(OP_WR,  2'd0, 10'h000, 10'h000, 10'h000);
    add(OP_WR,  2'd1, 10'h000, 10'h000, 10'h000);
    add(OP_RD,  2'd2, 10'h000, 10'h002, 10'h002);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_RD:  do_rd(vecs[i].addr, vecs[i].exp, vecs[i].exp_any, $sformatf("b_v%0d_rd", i));
        OP_WR:  do_wr(vecs[i].addr, vecs[i].dat);
        OP_PIN: do_pin(vecs[i].dat);
        default: do_irq(vecs[i].exp[0], vecs[i].exp_any[0], $sformatf("b_v%0d_irq", i));
      endcase
    end

`ifdef AVALON_INPUT_PIO_DEBOUNCE_EN
    // Short pulse on bit5 is filtered; a long hold gets through.
    do_pin(10'h085);
    do_wr(2'd3, 10'h3FF);
    do_rd(2'd3, 10'h000, 10'h000, "deb_clr");
    @(negedge clk);
    in_port = 10'h0A5;
    repeat (3) @(negedge clk);
    in_port = 10'h085;
    repeat (PIN_WAIT) @(negedge clk);
    do_rd(2'd0, 10'h085, 10'h085, "deb_glitch_data");
    do_rd(2'd3, 10'h000, 10'h000, "deb_glitch_edge");
    @(negedge clk);
    in_port = 10'h0A5;
    repeat (20) @(negedge clk);
    do_rd(2'd0, 10'h0A5, 10'h0A5, "deb_hold_data");
    do_rd(2'd3, 10'h020, 10'h020, "deb_hold_edge");
`else
    // Rising edge on bit2 lands in the same clock as a W1C of bit2 (and bit0).
    do_pin(10'h0A1);
    do_wr(2'd3, 10'h3FF);
    do_rd(2'd3, 10'h000, 10'h000, "race_pre");
    @(negedge clk);
    in_port = 10'h0A5;
    @(negedge clk);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h0000_0005;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    do_rd(2'd3, 10'h004, 10'h004, "race_set_wins");
`endif

    // Reset asserted mid-operation with an active irq.
    do_wr(2'd2, MID_BIT);
    do_irq(1'b1, 1'b1, "mid_irq_pre");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_irq", {31'd0, irq0}, 32'd0);
    check("mid_rst_irq_any", {31'd0, irq1}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (RST_WAIT) @(negedge clk);
    do_rd(2'd3, 10'h000, 10'h000, "mid_rst_edge");
    do_rd(2'd2, 10'h000, 10'h00F, "mid_rst_mask");
    do_rd(2'd0, 10'h0A5, 10'h0A5, "mid_rst_data");
    do_irq(1'b0, 1'b0, "mid_rst_irq_post");

    repeat (3) @(negedge clk);
    check("rd_idle", rd0, 32'd0);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
